cic_rate_scheduler: RTL and testbench

Sequences the I/Q CIC x8 interpolators from the single system clock, replacing divided clocks with one-cycle clock-enable strobes.
- Generates the CIC sample enable for the selected baud rate.
- Requests one new shaped-filter sample per symbol, and zero-stuffs and flags the sample if none is ready.
- Applies baud-rate changes only at a symbol boundary, then flushes the CIC integrators/combs under reset.
- Sits between the pulse-shaping filter outputs and both CIC instances, driving their clk_enable and reset.

---
 rtl/cic_rate_scheduler.sv | 146 ++++++++++++++
 tb/tb_cic_rate_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_rate_scheduler.sv
// Clock-enable scheduler for the I/Q CIC x8 interpolators: baud-rate strobes, sample requests,
// symbol-aligned rate changes with integrator flush. Optional underrun counter: CIC_UNDERRUN_CNT_EN.
module cic_rate_scheduler #(
    parameter int BASE_DIV  = 18,
    parameter int UPSAMP    = 8,
    parameter int FLUSH_LEN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  baud_rate,
    input  logic        rate_update,
    output logic        rate_busy,
    output logic [1:0]  active_rate,
    output logic        cic_ce,
    output logic        cic_rst,
    output logic        in_req,
    input  logic        in_valid,
    output logic        hold_zero,
    output logic        underrun
`ifdef CIC_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam int BASE_W  = (BASE_DIV  > 1) ? $clog2(BASE_DIV)  : 1;
    localparam int PHASE_W = (UPSAMP    > 1) ? $clog2(UPSAMP)    : 1;
    localparam int FLUSH_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    localparam logic [BASE_W-1:0]  BASE_LAST  = BASE_W'(BASE_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(UPSAMP - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        PEND  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BASE_W-1:0]  base_cnt;
    logic [2:0]         rate_cnt;
    logic [PHASE_W-1:0] phase;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [1:0]         pend_rate;
    logic               base_tick;
    logic [2:0]         rate_mask;
    logic               accept_update;
    logic               load_rate;
    logic               streaming;

    always_comb begin
        base_tick = (base_cnt == BASE_LAST);
        case (active_rate)
            2'b00:   rate_mask = 3'd7;
            2'b01:   rate_mask = 3'd3;
            2'b10:   rate_mask = 3'd1;
            default: rate_mask = 3'd0;
        endcase
        streaming     = (state == RUN) || (state == PEND);
        cic_ce        = base_tick && ((rate_cnt & rate_mask) == 3'd0) && (state != IDLE);
        in_req        = cic_ce && (phase == '0) && streaming;
        cic_rst       = (state == IDLE) || (state == FLUSH);
        rate_busy     = (state == FLUSH) || (state == PEND);
        accept_update = rate_update && !rate_busy;
    end

    // Next state; load_rate marks every entry into FLUSH, where the new rate takes over
    always_comb begin
        state_nxt = state;
        load_rate = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = FLUSH;
                    load_rate = 1'b1;
                end
                FLUSH: begin
                    if (cic_ce && (flush_cnt == FLUSH_LAST)) state_nxt = RUN;
                end
                RUN: begin
                    if (rate_update) state_nxt = PEND;
                end
                PEND: begin
                    if (cic_ce && (phase == PHASE_LAST)) begin
                        state_nxt = FLUSH;
                        load_rate = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base_cnt    <= '0;
            rate_cnt    <= '0;
            phase       <= '0;
            flush_cnt   <= '0;
            pend_rate   <= 2'b00;
            active_rate <= 2'b00;
            hold_zero   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state    <= state_nxt;
            base_cnt <= base_tick ? '0 : base_cnt + BASE_W'(1);
            underrun <= in_req && !in_valid;
            if (accept_update) pend_rate <= baud_rate;
            if (load_rate) begin
                active_rate <= pend_rate;
                rate_cnt    <= '0;
                phase       <= '0;
                flush_cnt   <= '0;
                hold_zero   <= 1'b0;
            end else begin
                if (base_tick) rate_cnt <= rate_cnt + 3'd1;
                if (cic_ce && (state == FLUSH)) flush_cnt <= flush_cnt + FLUSH_W'(1);
                if (cic_ce && streaming) phase <= (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
                // A starved request zero-stuffs until a real sample is consumed again
                if (in_req) hold_zero <= !in_valid;
            end
        end
    end

`ifdef CIC_UNDERRUN_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (underrun) begin
            underrun_cnt <= sat_inc16(underrun_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_cic_rate_scheduler.sv
// Scoreboard bench for cic_rate_scheduler: a time-based reference model predicts every
// cic_ce strobe and underrun pulse; a monitor pops and compares as the DUT produces them.
`timescale 1ns/1ps
module tb_cic_rate_scheduler;
    localparam int BASE_DIV  = 18;
    localparam int UPSAMP    = 8;
    localparam int FLUSH_LEN = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] baud_rate = 2'b00;
    logic       rate_update = 1'b0;
    logic       in_valid = 1'b0;
    logic       rate_busy;
    logic [1:0] active_rate;
    logic       cic_ce;
    logic       cic_rst;
    logic       in_req;
    logic       hold_zero;
    logic       underrun;
`ifdef CIC_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    cic_rate_scheduler #(
        .BASE_DIV (BASE_DIV),
        .UPSAMP   (UPSAMP),
        .FLUSH_LEN(FLUSH_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .baud_rate  (baud_rate),
        .rate_update(rate_update),
        .rate_busy  (rate_busy),
        .active_rate(active_rate),
        .cic_ce     (cic_ce),
        .cic_rst    (cic_rst),
        .in_req     (in_req),
        .in_valid   (in_valid),
        .hold_zero  (hold_zero),
        .underrun   (underrun)
`ifdef CIC_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int abs_cyc = 0;
    bit chk_en = 1'b0;
    int ur_pct = 20;

    typedef struct {
        int         cyc;
        logic       req;
        logic       rst;
        logic       busy;
        logic       hold;
        logic [1:0] rate;
    } ce_ev_t;

    ce_ev_t ce_q[$];
    int     ur_q[$];

    typedef enum int {M_IDLE, M_FLUSH, M_RUN, M_PEND} mode_t;
    mode_t      m_mode = M_IDLE;
    int         m_cyc = 0;
    int         m_tk = 0;
    int         m_nce = 0;
    int         m_nflush = 0;
    int         m_ur_cnt = 0;
    logic [1:0] m_active = 2'b00;
    logic [1:0] m_pend = 2'b00;
    logic       m_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, abs_cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        abs_cyc++;
    end

    // Reference model: time since reset gives base ticks, ticks since the last rate load give
    // the enable cadence, enables since RUN began give the symbol position.
    initial forever begin
        logic       tick, ce, req, busy, lod;
        logic [1:0] new_pend;
        int         per;
        ce_ev_t     e;
        @(negedge clk);
        per  = 1 << (3 - int'(m_active));
        tick = (m_cyc % BASE_DIV) == BASE_DIV - 1;
        ce   = tick && (m_mode != M_IDLE) && ((m_tk % per) == 0);
        req  = ce && (m_mode == M_RUN || m_mode == M_PEND) && ((m_nce % UPSAMP) == 0);
        busy = (m_mode == M_FLUSH) || (m_mode == M_PEND);
        if (chk_en && ce) begin
            e.cyc  = abs_cyc;
            e.req  = req;
            e.rst  = (m_mode == M_IDLE) || (m_mode == M_FLUSH);
            e.busy = busy;
            e.hold = m_hold;
            e.rate = m_active;
            ce_q.push_back(e);
        end
        if (reset) begin
            m_mode = M_IDLE; m_cyc = 0; m_tk = 0; m_nce = 0; m_nflush = 0;
            m_active = 2'b00; m_pend = 2'b00; m_hold = 1'b0; m_ur_cnt = 0;
        end else begin
            if (req && !in_valid) begin
                if (chk_en) ur_q.push_back(abs_cyc + 1);
                if (m_ur_cnt < 65535) m_ur_cnt++;
            end
            if (req) m_hold = !in_valid;
            m_cyc++;
            if (tick) m_tk++;
            new_pend = (rate_update && !busy) ? baud_rate : m_pend;
            lod = 1'b0;
            if (!enable) begin
                m_mode = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE:  lod = 1'b1;
                    M_FLUSH: if (ce) begin
                        m_nflush++;
                        if (m_nflush == FLUSH_LEN) begin
                            m_mode = M_RUN;
                            m_nce  = 0;
                        end
                    end
                    M_RUN: begin
                        if (ce) m_nce++;
                        if (rate_update) m_mode = M_PEND;
                    end
                    M_PEND: if (ce) begin
                        if ((m_nce % UPSAMP) == UPSAMP - 1) lod = 1'b1;
                        else m_nce++;
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
            if (lod) begin
                m_active = m_pend;
                m_tk = 0; m_nflush = 0; m_hold = 1'b0;
                m_mode = M_FLUSH;
            end
            m_pend = new_pend;
        end
    end

    // Monitor: consumes expected strobes as the DUT presents them
    initial forever begin
        ce_ev_t ev;
        @(negedge clk);
        #1;
        if (chk_en) begin
            while (ce_q.size() > 0 && ce_q[0].cyc < abs_cyc) begin
                tests++; fails++;
                $display("FAIL ce_missing: got no cic_ce, required one at cycle %0d", ce_q[0].cyc);
                void'(ce_q.pop_front());
            end
            while (ur_q.size() > 0 && ur_q[0] < abs_cyc) begin
                tests++; fails++;
                $display("FAIL underrun_missing: got no underrun, required one at cycle %0d", ur_q[0]);
                void'(ur_q.pop_front());
            end
            if (cic_ce !== 1'b0) begin
                tests++;
                if (ce_q.size() == 0 || ce_q[0].cyc != abs_cyc) begin
                    fails++;
                    $display("FAIL ce_unexpected: got cic_ce=%b at cycle %0d, required 0", cic_ce, abs_cyc);
                end else begin
                    ev = ce_q.pop_front();
                    check("in_req", in_req, ev.req);
                    check("cic_rst", cic_rst, ev.rst);
                    check("rate_busy", rate_busy, ev.busy);
                    check("hold_zero", hold_zero, ev.hold);
                    check("active_rate", active_rate, ev.rate);
                end
            end else if (in_req !== 1'b0) begin
                check("in_req_without_ce", in_req, 0);
            end
            if (underrun !== 1'b0) begin
                tests++;
                if (ur_q.size() == 0 || ur_q[0] != abs_cyc) begin
                    fails++;
                    $display("FAIL underrun_unexpected: got underrun=%b at cycle %0d, required 0", underrun, abs_cyc);
                end else begin
                    void'(ur_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(99) >= ur_pct);
        end
    endtask

    task automatic pulse_update(input logic [1:0] b);
        baud_rate   = b;
        rate_update = 1'b1;
        step(1);
        rate_update = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cic_rst"}, cic_rst, 1);
        check({tag, "_cic_ce"}, cic_ce, 0);
        check({tag, "_in_req"}, in_req, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_hold_zero"}, hold_zero, 0);
        check({tag, "_rate_busy"}, rate_busy, 0);
        check({tag, "_active_rate"}, active_rate, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", abs_cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check_reset_values("reset");
        reset = 1'b0;

        // Pending rate set in IDLE, then start at 76800
        pulse_update(2'b11);
        enable = 1'b1;
        step(8 * 18 + 20);
        check("start_rate_11", active_rate, 3);
        check("start_run_rst", cic_rst, 0);
        step(5 * 144 + 30);

        // Change to 9600 mid-symbol
        step($urandom_range(1, 140));
        pulse_update(2'b00);
        check("pend_busy", rate_busy, 1);
        step(144 + 8 * 144 + 3 * 1152 + 20);
        check("rate_00", active_rate, 0);

        // Change to 19200; a second request during FLUSH is dropped
        pulse_update(2'b01);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step(1);
            if (cic_rst === 1'b1) found = 1'b1;
        end
        check("flush_entry_seen", found, 1);
        step(3);
        pulse_update(2'b10);
        step(8 * 72 + 50);
        check("rate_01_kept", active_rate, 1);
        step(3 * 576 + 20);

        // enable dropped during PEND keeps the pending rate
        pulse_update(2'b11);
        step(3);
        check("pend_busy2", rate_busy, 1);
        enable = 1'b0;
        step(1);
        check("idle_cic_rst", cic_rst, 1);
        check("idle_cic_ce", cic_ce, 0);
        check("idle_busy", rate_busy, 0);
        step(20);
        enable = 1'b1;
        step(8 * 18 + 150);
        check("preserved_rate_11", active_rate, 3);

        // rate_update and enable fall in the same cycle
        baud_rate   = 2'b10;
        rate_update = 1'b1;
        enable      = 1'b0;
        step(1);
        rate_update = 1'b0;
        step(5);
        enable = 1'b1;
        step(8 * 36 + 60);
        check("same_cycle_rate_10", active_rate, 2);
        step(2 * 288);

        // Randomized rate changes and enable drops
        for (int k = 0; k < 6; k++) begin
            pulse_update(2'($urandom_range(3)));
            step($urandom_range(100, 2500));
            if ($urandom_range(3) == 0) begin
                enable = 1'b0;
                step($urandom_range(1, 30));
                enable = 1'b1;
            end
        end

        // Reset while running
        step(1500);
        reset = 1'b1;
        step(1);
        check_reset_values("midreset");
        reset = 1'b0;
        step(8 * 144 + 1152 + 100);

        ur_pct = 0;
        step(10);
        check("ce_queue_drained", ce_q.size(), 0);
        check("underrun_queue_drained", ur_q.size(), 0);
`ifdef CIC_UNDERRUN_CNT_EN
        check("underrun_cnt", underrun_cnt, m_ur_cnt);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
